// File: rtl/stage1_input_loader.sv
// stage1_input_loader
// Collects one frame of N_POINTS complex samples into a buffer in bit-reversed
// address order, then presents them as operand pairs (buf[2k], buf[2k+1]) to
// the first radix-2 butterfly stage with a constant W^0 twiddle.
// Optional feature: define STAGE1_OVERRUN_DET_EN to enable the sticky overrun
// flag (input offered while the loader is emitting). When it is undefined,
// overrun is tied low.
module stage1_input_loader #(
    parameter int N_POINTS = 8,
    parameter int LOG2N    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_real,
    input  logic signed [15:0]      in_imag,
    output logic                    pair_valid,
    input  logic                    pair_ready,
    output logic signed [15:0]      in1_real,
    output logic signed [15:0]      in1_imag,
    output logic signed [15:0]      in2_real,
    output logic signed [15:0]      in2_imag,
    output logic signed [15:0]      twiddle_real,
    output logic signed [15:0]      twiddle_imag,
    output logic [LOG2N-2:0]        pair_index,
    output logic                    frame_last,
    output logic                    overrun
);

    localparam int                 KW     = LOG2N - 1;
    localparam logic [LOG2N-1:0]   W_LAST = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0]   W_ONE  = LOG2N'(1);
    localparam logic [KW-1:0]      K_LAST = KW'(N_POINTS / 2 - 1);
    localparam logic [KW-1:0]      K_ONE  = KW'(1);
    localparam logic [KW-1:0]      K_ZERO = KW'(0);
    localparam logic signed [15:0] TW_ONE = 16'sh4000;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [LOG2N-1:0]  wr_cnt_r;
    logic [31:0]       mem_r [N_POINTS];

    logic              accept_s;
    logic              last_sample_s;
    logic              pair_fire_s;
    logic              last_pair_s;
    logic              load_pair_s;
    logic [KW-1:0]     k_next_s;
    logic [LOG2N-1:0]  addr_lo_s;
    logic [LOG2N-1:0]  addr_hi_s;

    // Reverse the bit order of a buffer address.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = {LOG2N{1'b0}};
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Handshake decode and address of the next pair to present.
    always_comb begin
        accept_s      = in_valid && in_ready;
        last_sample_s = accept_s && (wr_cnt_r == W_LAST);
        pair_fire_s   = pair_valid && pair_ready;
        last_pair_s   = pair_fire_s && (pair_index == K_LAST);
        load_pair_s   = last_sample_s || (pair_fire_s && !last_pair_s);
        if (last_sample_s) begin
            k_next_s = K_ZERO;
        end else begin
            k_next_s = pair_index + K_ONE;
        end
        addr_lo_s = {k_next_s, 1'b0};
        addr_hi_s = {k_next_s, 1'b1};
    end

    // Next-state logic: FILL until a full frame is in, EMIT until the last pair is taken.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FILL: begin
                if (last_sample_s) begin
                    next_state_s = EMIT;
                end else begin
                    next_state_s = FILL;
                end
            end
            EMIT: begin
                if (last_pair_s) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = EMIT;
                end
            end
            default: begin
                next_state_s = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered in_ready: low in reset, then mirrors the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (next_state_s == FILL);
        end
    end

    // Write counter; wraps naturally after the last sample of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r <= {LOG2N{1'b0}};
        end else if (accept_s) begin
            wr_cnt_r <= wr_cnt_r + W_ONE;
        end else begin
            wr_cnt_r <= wr_cnt_r;
        end
    end

    // Sample buffer, written in bit-reversed order; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[bitrev(wr_cnt_r)] <= {in_real, in_imag};
        end
    end

    // Pair output registers. Pair 0 never contains the final sample's slot
    // (address N_POINTS-1), so it can be read on the same edge that writes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_valid   <= 1'b0;
            pair_index   <= K_ZERO;
            frame_last   <= 1'b0;
            in1_real     <= 16'sh0000;
            in1_imag     <= 16'sh0000;
            in2_real     <= 16'sh0000;
            in2_imag     <= 16'sh0000;
            twiddle_real <= 16'sh0000;
            twiddle_imag <= 16'sh0000;
        end else if (load_pair_s) begin
            pair_valid   <= 1'b1;
            pair_index   <= k_next_s;
            frame_last   <= (k_next_s == K_LAST);
            in1_real     <= mem_r[addr_lo_s][31:16];
            in1_imag     <= mem_r[addr_lo_s][15:0];
            in2_real     <= mem_r[addr_hi_s][31:16];
            in2_imag     <= mem_r[addr_hi_s][15:0];
            twiddle_real <= TW_ONE;
            twiddle_imag <= 16'sh0000;
        end else if (last_pair_s) begin
            pair_valid   <= 1'b0;
            pair_index   <= K_ZERO;
            frame_last   <= 1'b0;
        end
    end

`ifdef STAGE1_OVERRUN_DET_EN
    // Sticky overrun: input offered while emitting; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (in_valid && (state_r == EMIT)) begin
            overrun <= 1'b1;
        end else begin
            overrun <= overrun;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_stage1_input_loader.sv
// Testbench for stage1_input_loader: directed frames plus randomized traffic
// checked against a frame-level reference model (bit-reversed buffer, pairs
// of adjacent buffer entries, handshake-driven consumption).
module tb_stage1_input_loader;

    localparam int N = 8;
    localparam int L = 3;
`ifdef STAGE1_OVERRUN_DET_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] r1;
        logic [15:0] i1;
        logic [15:0] r2;
        logic [15:0] i2;
        logic [1:0]  idx;
        logic        last;
    } pair_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        pair_valid;
    logic        pair_ready;
    logic [15:0] in1_real;
    logic [15:0] in1_imag;
    logic [15:0] in2_real;
    logic [15:0] in2_imag;
    logic [15:0] twiddle_real;
    logic [15:0] twiddle_imag;
    logic [1:0]  pair_index;
    logic        frame_last;
    logic        overrun;

    int          n_checks;
    int          n_errors;

    logic [31:0] frame_q [$];
    pair_t       pairs_q [$];
    bit          emit_m;
    bit          ovr_m;

    stage1_input_loader #(.N_POINTS(N), .LOG2N(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .pair_valid   (pair_valid),
        .pair_ready   (pair_ready),
        .in1_real     (in1_real),
        .in1_imag     (in1_imag),
        .in2_real     (in2_real),
        .in2_imag     (in2_imag),
        .twiddle_real (twiddle_real),
        .twiddle_imag (twiddle_imag),
        .pair_index   (pair_index),
        .frame_last   (frame_last),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < L; b++) begin
            r = r * 2 + ((v >> b) % 2);
        end
        return r;
    endfunction

    // Turn a completed frame into the ordered list of expected pairs.
    task automatic build_pairs();
        logic [31:0] bm [N];
        pair_t p;
        for (int i = 0; i < N; i++) bm[brev(i)] = frame_q[i];
        for (int k = 0; k < N / 2; k++) begin
            p.r1   = bm[2*k][31:16];
            p.i1   = bm[2*k][15:0];
            p.r2   = bm[2*k+1][31:16];
            p.i2   = bm[2*k+1][15:0];
            p.idx  = 2'(k);
            p.last = (k == N / 2 - 1);
            pairs_q.push_back(p);
        end
        frame_q.delete();
        emit_m = 1'b1;
    endtask

    task automatic check_outputs();
        pair_t p;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, !emit_m});
        check_eq("pair_valid", {31'd0, pair_valid}, {31'd0, emit_m});
        check_eq("overrun", {31'd0, overrun}, {31'd0, ovr_m});
        if (emit_m && pairs_q.size() > 0) begin
            p = pairs_q[0];
            check_eq("in1_real", {16'd0, in1_real}, {16'd0, p.r1});
            check_eq("in1_imag", {16'd0, in1_imag}, {16'd0, p.i1});
            check_eq("in2_real", {16'd0, in2_real}, {16'd0, p.r2});
            check_eq("in2_imag", {16'd0, in2_imag}, {16'd0, p.i2});
            check_eq("twiddle_real", {16'd0, twiddle_real}, 32'h0000_4000);
            check_eq("twiddle_imag", {16'd0, twiddle_imag}, 32'h0000_0000);
            check_eq("pair_index", {30'd0, pair_index}, {30'd0, p.idx});
            check_eq("frame_last", {31'd0, frame_last}, {31'd0, p.last});
        end
    endtask

    // One clock: check what is visible now, drive new inputs, advance the model.
    task automatic cycle(input bit iv, input logic [15:0] r, input logic [15:0] im, input bit pr);
        check_outputs();
        in_valid   = iv;
        in_real    = r;
        in_imag    = im;
        pair_ready = pr;
        if (!emit_m) begin
            if (iv) begin
                frame_q.push_back({r, im});
                if (frame_q.size() == N) build_pairs();
            end
        end else begin
            if (iv && OVR_EN) ovr_m = 1'b1;
            if (pr) begin
                void'(pairs_q.pop_front());
                if (pairs_q.size() == 0) emit_m = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        pair_ready = 1'b0;
        in_real    = 16'h0000;
        in_imag    = 16'h0000;
        #1;
        frame_q.delete();
        pairs_q.delete();
        emit_m = 1'b0;
        ovr_m  = 1'b0;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_pair_valid", {31'd0, pair_valid}, 32'd0);
        check_eq("rst_frame_last", {31'd0, frame_last}, 32'd0);
        check_eq("rst_pair_index", {30'd0, pair_index}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        check_eq("rst_operands", {in1_real, in2_imag}, 32'd0);
        check_eq("rst_operands2", {in1_imag, in2_real}, 32'd0);
        check_eq("rst_twiddle", {twiddle_real, twiddle_imag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("in_ready_at_deassert", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        emit_m     = 1'b0;
        ovr_m      = 1'b0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        pair_ready = 1'b0;
        in_real    = 16'h0000;
        in_imag    = 16'h0000;
        #2;
        do_reset();

        // Ramp frame real=i, imag=-i, consumer always ready.
        for (int i = 0; i < N; i++) cycle(1'b1, 16'(i), 16'(-i), 1'b1);
        repeat (5) cycle(1'b0, 16'h0000, 16'h0000, 1'b1);

        // Stall five cycles on pair 1.
        for (int i = 0; i < N; i++) cycle(1'b1, 16'(i + 20), 16'(i), 1'b1);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b1);
        repeat (5) cycle(1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (4) cycle(1'b0, 16'h0000, 16'h0000, 1'b1);

        // Partial frame discarded by reset, then a fresh frame 10..17.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 99), 16'(i + 99), 1'b1);
        do_reset();
        for (int i = 0; i < N; i++) cycle(1'b1, 16'(i + 10), 16'(i + 100), 1'b1);
        repeat (5) cycle(1'b0, 16'h0000, 16'h0000, 1'b1);

        // Extreme values pass bit-exact.
        for (int i = 0; i < N; i++) begin
            if (i % 2 == 0) cycle(1'b1, 16'h8000, 16'h7FFF, 1'b1);
            else            cycle(1'b1, 16'h7FFF, 16'h8000, 1'b1);
        end
        repeat (5) cycle(1'b0, 16'h0000, 16'h0000, 1'b1);

        // Back-to-back frames with in_valid held high (sets overrun when enabled).
        repeat (60) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        do_reset();

        // Randomized traffic and backpressure.
        repeat (800) cycle($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                           $urandom_range(0, 9) < 6);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stage1_input_loader.md
STAGE1_INPUT_LOADER -- requirements
Module: stage1_input_loader

Interface
REQ-001 The block SHALL have parameter N_POINTS, default 8: FFT size, power of two, 4..64.
REQ-002 The block SHALL have parameter LOG2N, default 3: log2(N_POINTS).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: a sample is present on in_real/in_imag.
REQ-006 Port in_ready, output, 1 bit: the loader accepts a sample this cycle.
REQ-007 Port in_real, input, 16 bits: signed sample, integer format.
REQ-008 Port in_imag, input, 16 bits: signed sample, integer format.
REQ-009 Port pair_valid, output, 1 bit: a butterfly operand pair is presented.
REQ-010 Port pair_ready, input, 1 bit: the downstream butterfly consumes the pair.
REQ-011 Ports in1_real, in1_imag, in2_real and in2_imag, outputs, 16 bits each: signed operands to butterfly stage 1.
REQ-012 Ports twiddle_real and twiddle_imag, outputs, 16 bits each: signed twiddle, Q2.14.
REQ-013 Port pair_index, output, LOG2N-1 bits: index k of the presented pair.
REQ-014 Port frame_last, output, 1 bit: high with the final pair of a frame.
REQ-015 Port overrun, output, 1 bit: sticky error flag (see Configuration).

Function
REQ-016 The block SHALL implement states FILL and EMIT; FILL SHALL be the reset state.
REQ-017 in_ready SHALL be 1 in FILL and 0 in EMIT.
REQ-018 In FILL, on in_valid&&in_ready, the sample SHALL be written to buffer address bitrev(wr_cnt), and wr_cnt (LOG2N bits) SHALL increment.
REQ-019 Acceptance of the sample with wr_cnt==N_POINTS-1 SHALL wrap wr_cnt to 0 and move the state to EMIT on the same edge.
REQ-020 pair_valid SHALL rise in the first cycle after that edge (latency 1 clock from the last sample accepted).
REQ-021 In EMIT, pair k SHALL present in1 = buf[2k] and in2 = buf[2k+1], with pair_index=k, for k = 0..N_POINTS/2-1 in ascending order.
REQ-022 twiddle_real SHALL be 16'sh4000 (+1.0) and twiddle_imag SHALL be 0 for every pair, since stage 1 uses W^0 only.
REQ-023 All pair outputs SHALL be registered and held stable while pair_valid&&!pair_ready.
REQ-024 Each pair_valid&&pair_ready SHALL advance k by 1.
REQ-025 When the pair with k=N_POINTS/2-1 is accepted, frame_last SHALL have been 1 for that pair, k SHALL wrap to 0, the state SHALL return to FILL, and pair_valid SHALL drop the next cycle.
REQ-026 in_valid during EMIT SHALL be ignored, and no buffer write SHALL occur.
REQ-027 A pair_ready held low indefinitely SHALL stall EMIT with no data loss.
REQ-028 Data SHALL pass unmodified: no scaling, rounding or sign change.

Reset
REQ-029 On rst=1, the state SHALL go to FILL and wr_cnt and k SHALL go to 0, immediately and asynchronously.
REQ-030 On rst=1, pair_valid, frame_last, pair_index, overrun and all operand outputs SHALL go to 0; twiddle outputs SHALL go to 0.
REQ-031 During rst=1, in_ready SHALL be 0; it SHALL return to 1 the first cycle after deassertion.
REQ-032 Reset mid-FILL or mid-EMIT SHALL discard the partial frame; buffer contents need not be cleared.

Configuration
REQ-033 With macro STAGE1_OVERRUN_DET_EN defined, overrun SHALL set to 1 on any cycle with in_valid=1 and state=EMIT, and SHALL stay 1 until rst.
REQ-034 Without STAGE1_OVERRUN_DET_EN, overrun SHALL be tied to 0, with no detection logic and the port list unchanged.

Verification
REQ-035 Scenario: N=8, pair_ready=1, samples i=0..7 with real=i and imag=-i -> pairs (in1,in2) in order (0,4), (2,6), (1,5), (3,7), imag negated, twiddle 0x4000/0, frame_last only on pair 3.
REQ-036 Scenario: same frame with pair_ready low for 5 cycles on pair 1 -> outputs (2,6) held, then the sequence completes; in_ready stays 0 throughout EMIT.
REQ-037 Scenario: 3 samples accepted, then a rst pulse, then a full frame 10..17 -> first pair is (10,14), no stale data.
REQ-038 Scenario: in_valid held high through EMIT with the macro defined -> overrun=1 and sticky until rst, and the frame output is unaltered; without the macro, overrun=0.
REQ-039 Scenario: back-to-back frames with in_valid constant -> the second frame's first sample is accepted the cycle after the last pair handshake.
REQ-040 Scenario: samples 0x8000/0x7FFF -> emitted bit-exact.
